cla_pipe_addsub: RTL and testbench

- Parametrised, two-stage pipelined carry-look-ahead add/subtract unit built from 4-bit CLA groups.
- Stage 1 resolves the low half of the operands and the carry into the high half. Stage 2 resolves the high half and the N/Z/V flags.
- Valid/ready handshake on both sides and a synchronous flush, so it sits in the CPU execute stage and tolerates stalls and squashes.

---
 rtl/cla_pipe_addsub.sv | 179 +++++++++++++++++
 tb/tb_cla_pipe_addsub.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cla_pipe_addsub.sv
// cla_pipe_addsub: two-stage pipelined carry-look-ahead add/subtract unit.
// Stage 1 adds the low half and registers the carry into the high half.
// Stage 2 adds the high half and registers the result with N/Z/V/C flags.
// Valid/ready on both sides plus a synchronous flush for squashes.
// Optional: define CLA_SAT_EN to saturate the result on signed overflow.
module cla_pipe_addsub #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_sub,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             out_ovfl,
  output logic             out_neg,
  output logic             out_zero,
  output logic [TAG_W-1:0] out_tag
);

  localparam int unsigned HALF = WIDTH / 2;
  localparam int unsigned NGRP = HALF / 4;

  // 4-bit CLA group: returns {group_g, group_p, sum[3:0]}; all internal
  // carries are look-ahead terms, nothing ripples inside the group.
  function automatic logic [5:0] cla4(input logic [3:0] a,
                                      input logic [3:0] b,
                                      input logic       cin);
    logic [3:0] g;
    logic [3:0] p;
    logic [3:0] c;
    logic       gg;
    logic       pg;
    g    = a & b;
    p    = a ^ b;
    c[0] = cin;
    c[1] = g[0] | (p[0] & cin);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) |
           (p[2] & p[1] & p[0] & cin);
    gg   = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) |
           (p[3] & p[2] & p[1] & g[0]);
    pg   = &p;
    return {gg, pg, p ^ c};
  endfunction

  // One half-width adder: groups chained by G | (P & Cin); returns {cout, sum}.
  function automatic logic [HALF:0] cla_half(input logic [HALF-1:0] a,
                                             input logic [HALF-1:0] b,
                                             input logic            cin);
    logic            c;
    logic [5:0]      r;
    logic [HALF-1:0] s;
    c = cin;
    s = '0;
    for (int unsigned i = 0; i < NGRP; i++) begin
      r            = cla4(a[4*i +: 4], b[4*i +: 4], c);
      s[4*i +: 4]  = r[3:0];
      c            = r[5] | (r[4] & c);
    end
    return {c, s};
  endfunction

  // Stage 1 registers
  logic            s1_valid;
  logic [HALF-1:0] s1_sum_lo;
  logic            s1_c_hi;
  logic [HALF-1:0] s1_a_hi;
  logic [HALF-1:0] s1_b_hi;
  logic [TAG_W-1:0] s1_tag;

  // Handshake / advance terms
  logic s2_adv_c;
  logic s1_adv_c;
  logic accept_c;
  logic s2_load_c;

  assign s2_adv_c  = !out_valid || out_ready;
  assign s1_adv_c  = !s1_valid || s2_adv_c;
  assign in_ready  = s1_adv_c && !flush;
  assign accept_c  = in_valid && in_ready;
  assign s2_load_c = s2_adv_c && s1_valid && !flush;

  // Stage 1 datapath: operand conditioning and low-half addition.
  logic [WIDTH-1:0] b_eff_c;
  logic [HALF:0]    lo_res_c;

  always_comb begin
    b_eff_c  = in_sub ? ~in_b : in_b;
    lo_res_c = cla_half(in_a[HALF-1:0], b_eff_c[HALF-1:0], in_sub);
  end

  // Stage 2 datapath: high-half addition, overflow and optional saturation.
  logic [HALF:0]    hi_res_c;
  logic [WIDTH-1:0] wrap_c;
  logic [WIDTH-1:0] res_c;
  logic             ovfl_c;

  always_comb begin
    hi_res_c = cla_half(s1_a_hi, s1_b_hi, s1_c_hi);
    wrap_c   = {hi_res_c[HALF-1:0], s1_sum_lo};
    ovfl_c   = (s1_a_hi[HALF-1] == s1_b_hi[HALF-1]) &&
               (wrap_c[WIDTH-1] != s1_a_hi[HALF-1]);
    res_c    = wrap_c;
`ifdef CLA_SAT_EN
    if (ovfl_c) begin
      res_c = s1_a_hi[HALF-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                              : {1'b0, {(WIDTH-1){1'b1}}};
    end
`endif
  end

  // Stage 1 valid: flush squashes, otherwise refill on advance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
    end else if (flush) begin
      s1_valid <= 1'b0;
    end else if (s1_adv_c) begin
      s1_valid <= in_valid;
    end
  end

  // Stage 1 data: captured only on an accepted transfer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_sum_lo <= '0;
      s1_c_hi   <= 1'b0;
      s1_a_hi   <= '0;
      s1_b_hi   <= '0;
      s1_tag    <= '0;
    end else if (accept_c) begin
      s1_sum_lo <= lo_res_c[HALF-1:0];
      s1_c_hi   <= lo_res_c[HALF];
      s1_a_hi   <= in_a[WIDTH-1:HALF];
      s1_b_hi   <= b_eff_c[WIDTH-1:HALF];
      s1_tag    <= in_tag;
    end
  end

  // Stage 2 valid: flush squashes, bubbles from stage 1 clear it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (s2_adv_c) begin
      out_valid <= s1_valid;
    end
  end

  // Stage 2 data: result and flags, held stable while stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_sum  <= '0;
      out_cout <= 1'b0;
      out_ovfl <= 1'b0;
      out_neg  <= 1'b0;
      out_zero <= 1'b0;
      out_tag  <= '0;
    end else if (s2_load_c) begin
      out_sum  <= res_c;
      out_cout <= hi_res_c[HALF];
      out_ovfl <= ovfl_c;
      out_neg  <= res_c[WIDTH-1];
      out_zero <= (res_c == '0);
      out_tag  <= s1_tag;
    end
  end

endmodule

// File: tb/tb_cla_pipe_addsub.sv
// Bench for cla_pipe_addsub: directed vector table, stall/flush/reset
// sequences and randomized traffic against an arithmetic reference model.
module tb_cla_pipe_addsub;

  localparam int unsigned W  = 16;
  localparam int unsigned TW = 4;
  localparam int          NTAB = 9;

  typedef struct {
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic          sub;
    logic [TW-1:0] tag;
    logic [W-1:0]  sum;
    logic          cout;
    logic          ovfl;
    logic          neg;
    logic          zero;
  } vec_t;

  logic          clk;
  logic          rst_n;
  logic          flush;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_a;
  logic [W-1:0]  in_b;
  logic          in_sub;
  logic [TW-1:0] in_tag;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_sum;
  logic          out_cout;
  logic          out_ovfl;
  logic          out_neg;
  logic          out_zero;
  logic [TW-1:0] out_tag;

  int   checks;
  int   failures;
  vec_t drv_exp;
  vec_t q[$];
  vec_t mon_e;
  vec_t tab[NTAB];
  vec_t ops[4];

  cla_pipe_addsub #(.WIDTH(W), .TAG_W(TW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_sub    (in_sub),
    .in_tag    (in_tag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_cout  (out_cout),
    .out_ovfl  (out_ovfl),
    .out_neg   (out_neg),
    .out_zero  (out_zero),
    .out_tag   (out_tag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: plain signed/unsigned integer arithmetic on the operands.
  function automatic vec_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic sub, input logic [TW-1:0] tag);
    vec_t v;
    int   ua, ub, sa, sb, sr;
    ua = int'(a);
    ub = int'(b);
    sa = int'($signed(a));
    sb = int'($signed(b));
    sr = sub ? sa - sb : sa + sb;
    v.a    = a;
    v.b    = b;
    v.sub  = sub;
    v.tag  = tag;
    v.ovfl = (sr > 32767) || (sr < -32768);
    v.cout = sub ? (ua >= ub) : ((ua + ub) > 65535);
    v.sum  = 16'(sub ? ua - ub : ua + ub);
`ifdef CLA_SAT_EN
    if (v.ovfl) v.sum = a[W-1] ? 16'h8000 : 16'h7FFF;
`endif
    v.neg  = v.sum[W-1];
    v.zero = (v.sum == 16'h0000);
    return v;
  endfunction

  function automatic vec_t mk(input logic [W-1:0] a, input logic [W-1:0] b,
                              input logic sub, input logic [TW-1:0] tag,
                              input logic [W-1:0] sum, input logic cout,
                              input logic ovfl, input logic neg, input logic zero);
    vec_t v;
    v.a = a; v.b = b; v.sub = sub; v.tag = tag;
    v.sum = sum; v.cout = cout; v.ovfl = ovfl; v.neg = neg; v.zero = zero;
    return v;
  endfunction

  function automatic logic [W-1:0] pick();
    case ($urandom % 6)
      0: return 16'h0000;
      1: return 16'hFFFF;
      2: return 16'h7FFF;
      3: return 16'h8000;
      default: return 16'($urandom);
    endcase
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%0h exp=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic cmp_out(input string nm, input vec_t e);
    checks++;
    if ({out_sum, out_cout, out_ovfl, out_neg, out_zero, out_tag} !==
        {e.sum, e.cout, e.ovfl, e.neg, e.zero, e.tag}) begin
      failures++;
      $display("FAIL %s act sum=%h c=%b v=%b n=%b z=%b tag=%h exp sum=%h c=%b v=%b n=%b z=%b tag=%h t=%0t",
               nm, out_sum, out_cout, out_ovfl, out_neg, out_zero, out_tag,
               e.sum, e.cout, e.ovfl, e.neg, e.zero, e.tag, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input vec_t e);
    in_valid = 1'b1;
    in_a     = e.a;
    in_b     = e.b;
    in_sub   = e.sub;
    in_tag   = e.tag;
    drv_exp  = e;
  endtask

  task automatic idle();
    in_valid = 1'b0;
  endtask

  // Scoreboard: every delivered result must match the oldest accepted op.
  always @(negedge clk) begin
    if (!rst_n) begin
      q.delete();
    end else begin
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL spurious_result act=valid tag=%h exp=no pending op t=%0t", out_tag, $time);
        end else begin
          mon_e = q.pop_front();
          cmp_out("scoreboard", mon_e);
        end
      end
      if (flush) q.delete();
      if (in_valid && in_ready) q.push_back(drv_exp);
    end
  end

  initial begin
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    flush    = 1'b0;
    out_ready = 1'b1;
    in_valid = 1'b0;
    in_a     = '0;
    in_b     = '0;
    in_sub   = 1'b0;
    in_tag   = '0;
    drv_exp  = model(16'h0, 16'h0, 1'b0, 4'h0);

    // Directed vectors with hand-derived expectations.
    tab[0] = mk(16'h1234, 16'h0001, 1'b0, 4'h0, 16'h1235, 1'b0, 1'b0, 1'b0, 1'b0);
    tab[1] = mk(16'h00FF, 16'h0001, 1'b0, 4'h1, 16'h0100, 1'b0, 1'b0, 1'b0, 1'b0);
    tab[2] = mk(16'hFFFF, 16'h0001, 1'b0, 4'h2, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b1);
`ifdef CLA_SAT_EN
    tab[3] = mk(16'h7FFF, 16'h0001, 1'b0, 4'h3, 16'h7FFF, 1'b0, 1'b1, 1'b0, 1'b0);
    tab[4] = mk(16'h8000, 16'h0001, 1'b1, 4'h4, 16'h8000, 1'b1, 1'b1, 1'b1, 1'b0);
    tab[7] = mk(16'h8000, 16'h8000, 1'b0, 4'h7, 16'h8000, 1'b1, 1'b1, 1'b1, 1'b0);
`else
    tab[3] = mk(16'h7FFF, 16'h0001, 1'b0, 4'h3, 16'h8000, 1'b0, 1'b1, 1'b1, 1'b0);
    tab[4] = mk(16'h8000, 16'h0001, 1'b1, 4'h4, 16'h7FFF, 1'b1, 1'b1, 1'b0, 1'b0);
    tab[7] = mk(16'h8000, 16'h8000, 1'b0, 4'h7, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b1);
`endif
    tab[5] = mk(16'h0005, 16'h0005, 1'b1, 4'h5, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b1);
    tab[6] = mk(16'h0003, 16'h0005, 1'b1, 4'h6, 16'hFFFE, 1'b0, 1'b0, 1'b1, 1'b0);
    tab[8] = mk(16'h0000, 16'h0000, 1'b1, 4'h8, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b1);

    // Reset state.
    #12;
    chk("reset_out_valid", 32'(out_valid), 32'h0);
    chk("reset_outputs", 32'({out_sum, out_cout, out_ovfl, out_neg, out_zero, out_tag}), 32'h0);
    step();
    rst_n = 1'b1;
    #1;
    chk("reset_in_ready", 32'(in_ready), 32'h1);
    step();

    // Back-to-back table ops: result two cycles after presentation, in order.
    for (int t = 0; t < NTAB + 3; t++) begin
      step();
      if (t >= 2 && t - 2 < NTAB) begin
        chk("tab_valid", 32'(out_valid), 32'h1);
        cmp_out("tab_result", tab[t-2]);
      end else begin
        chk("tab_idle_valid", 32'(out_valid), 32'h0);
      end
      if (t < NTAB) drive(tab[t]);
      else idle();
    end
    step();

    // Backpressure: out_ready low for 4 cycles with in_valid high.
    ops[0] = model(16'h4321, 16'h1111, 1'b0, 4'hA);
    ops[1] = model(16'h9000, 16'h9000, 1'b0, 4'hB);
    ops[2] = model(16'h0010, 16'h0020, 1'b1, 4'hC);
    ops[3] = model(16'hABCD, 16'h0001, 1'b1, 4'hD);
    out_ready = 1'b0;
    begin
      int idx;
      idx = 0;
      for (int t = 0; t < 4; t++) begin
        step();
        if (t >= 2) begin
          chk("bp_stall_valid", 32'(out_valid), 32'h1);
          cmp_out("bp_stall_hold", ops[0]);
        end else begin
          chk("bp_fill_valid", 32'(out_valid), 32'h0);
        end
        drive(ops[idx]);
        #1;
        chk("bp_in_ready", 32'(in_ready), (t < 2) ? 32'h1 : 32'h0);
        if (in_ready) idx++;
      end
    end
    step();
    idle();
    out_ready = 1'b1;
    for (int t = 0; t < 4; t++) step();
    chk("bp_drained", 32'(q.size()), 32'h0);

    // Flush with two ops in flight.
    ops[0] = model(16'h0101, 16'h0202, 1'b0, 4'h1);
    ops[1] = model(16'h0303, 16'h0404, 1'b0, 4'h2);
    ops[2] = model(16'h0505, 16'h0606, 1'b0, 4'h3);
    ops[3] = model(16'h7000, 16'h1000, 1'b0, 4'h4);
    step(); drive(ops[0]);
    step(); drive(ops[1]);
    step(); drive(ops[2]); flush = 1'b1;
    #1;
    chk("flush_in_ready", 32'(in_ready), 32'h0);
    step();
    flush = 1'b0;
    chk("flush_valid_next", 32'(out_valid), 32'h0);
    drive(ops[3]);
    step();
    idle();
    chk("flush_bubble", 32'(out_valid), 32'h0);
    step();
    chk("flush_after_valid", 32'(out_valid), 32'h1);
    cmp_out("flush_after_result", ops[3]);
    step();
    chk("flush_only_one", 32'(out_valid), 32'h0);
    step();

    // Reset mid-stream with three ops issued.
    step(); drive(model(16'h1111, 16'h2222, 1'b0, 4'h5));
    step(); drive(model(16'h3333, 16'h4444, 1'b1, 4'h6));
    step(); drive(model(16'hFFFF, 16'hFFFF, 1'b0, 4'h7));
    step();
    idle();
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_mid_valid", 32'(out_valid), 32'h0);
    chk("rst_mid_outputs", 32'({out_sum, out_cout, out_ovfl, out_neg, out_zero, out_tag}), 32'h0);
    step();
    step();
    rst_n = 1'b1;
    #1;
    chk("rst_release_ready", 32'(in_ready), 32'h1);
    for (int t = 0; t < 4; t++) begin
      step();
      chk("rst_no_stale", 32'(out_valid), 32'h0);
    end

    // Randomized traffic with stalls and occasional flushes.
    for (int t = 0; t < 400; t++) begin
      step();
      drive(model(pick(), pick(), 1'($urandom % 2), 4'($urandom)));
      in_valid  = (($urandom % 4) != 0);
      out_ready = (($urandom % 3) != 0);
      flush     = (($urandom % 40) == 0);
    end
    step();
    idle();
    flush = 1'b0;
    out_ready = 1'b1;
    for (int t = 0; t < 5; t++) step();
    chk("rand_drained", 32'(q.size()), 32'h0);
    chk("rand_idle_valid", 32'(out_valid), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
